ant_table_scheduler: RTL

- Sequential owner of the per-router ant pheromone table.
- Arbitrates between per-input-port next-hop lookup requests (forward packets/ants) and backward-ant reinforcement updates.
- Serializes all table accesses through one FSM, with an optional periodic evaporation sweep.
- Sits between the router input units and the output-port allocator; the next-hop result is a one-hot output-port vector.

---
 rtl/ant_table_scheduler_if.sv | 35 +++
 rtl/ant_table_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ant_table_scheduler_if.sv
// ant_table_scheduler_if: groups the lookup and update request/response signals
// of the pheromone-table scheduler into one bundle.
// Ports: the lookup request bus (per-port req/dest/parent), the grant and response
// signals, the backward-ant update handshake, and the busy flag.
// Modports: master drives the requests (router side); slave is the scheduler.
interface ant_table_scheduler_if #(
  parameter int PORTS = 5,
  parameter int NODES = 16
);
  localparam int DW = $clog2(NODES);
  localparam int PW = $clog2(PORTS);

  logic [PORTS-1:0]    i_lk_req;
  logic [PORTS*DW-1:0] i_lk_dest;
  logic [PORTS*PW-1:0] i_lk_parent;
  logic [PORTS-1:0]    o_lk_gnt;
  logic                o_rsp_valid;
  logic [PW-1:0]       o_rsp_port;
  logic [PORTS-1:0]    o_rsp_next;
  logic                i_upd_valid;
  logic [DW-1:0]       i_upd_dest;
  logic [PW-1:0]       i_upd_parent;
  logic                o_upd_ready;
  logic                o_busy;

  modport master (
    output i_lk_req, i_lk_dest, i_lk_parent, i_upd_valid, i_upd_dest, i_upd_parent,
    input  o_lk_gnt, o_rsp_valid, o_rsp_port, o_rsp_next, o_upd_ready, o_busy
  );

  modport slave (
    input  i_lk_req, i_lk_dest, i_lk_parent, i_upd_valid, i_upd_dest, i_upd_parent,
    output o_lk_gnt, o_rsp_valid, o_rsp_port, o_rsp_next, o_upd_ready, o_busy
  );
endinterface

// File: rtl/ant_table_scheduler.sv
// ant_table_scheduler: owns the per-router pheromone table; serializes next-hop
//   lookups, backward-ant reinforcement updates and (optionally) evaporation sweeps.
// Latency: lookup granted at T, response at T+2; one operation per 3 cycles.
// Backpressure: requests are level-held until granted; nothing is granted while busy.
// Ports: i_clk, i_reset_n (async active-low) plus bus (ant_table_scheduler_if.slave):
//   i_lk_req/i_lk_dest/i_lk_parent -> o_lk_gnt, o_rsp_valid/o_rsp_port/o_rsp_next;
//   i_upd_valid/i_upd_dest/i_upd_parent -> o_upd_ready; o_busy = FSM not idle.
// Build option: define ANT_EVAPORATION_EN to add the periodic evaporation sweep.
module ant_table_scheduler #(
  parameter int PORTS       = 5,
  parameter int NODES       = 16,
  parameter int PH_WIDTH    = 8,
  parameter int PH_MAX      = 255,
  parameter int PH_MIN      = 0,
  parameter int PH_INIT     = 8,
  parameter int UPD_STEP    = 4,
  parameter int EVAP_PERIOD = 1024
) (
  input logic                  i_clk,
  input logic                  i_reset_n,
  ant_table_scheduler_if.slave bus
);
  localparam int DW = $clog2(NODES);
  localparam int PW = $clog2(PORTS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_LK_RSP = 3'd2;
  localparam logic [2:0] S_UPD_WB = 3'd3;
`ifdef ANT_EVAPORATION_EN
  localparam logic [2:0] S_EVAP   = 3'd4;
`endif

  logic [2:0]          state;
  logic [PH_WIDTH-1:0] tbl   [NODES][PORTS];
  logic [PH_WIDTH-1:0] row_q [PORTS];
  logic [PH_WIDTH-1:0] upd_row [PORTS];
  logic [DW-1:0]       op_dest;
  logic [PW-1:0]       op_parent;
  logic [PW-1:0]       op_port;
  logic                op_is_lk;
  logic                op_oor;
  logic                lk_first;
  logic [PW-1:0]       rr_ptr;

  logic                rr_any;
  logic [PW-1:0]       rr_sel;
  logic [DW-1:0]       sel_dest;
  logic [PW-1:0]       sel_parent;
  logic                evap_go;
  logic                take_lk;
  logic                take_upd;
  logic [PORTS-1:0]    lk_next;

  // Round-robin search starting one past the last granted port.
  always_comb begin
    int idx;
    rr_any = 1'b0;
    rr_sel = '0;
    for (int i = 1; i <= PORTS; i++) begin
      idx = (int'(rr_ptr) + i) % PORTS;
      if (!rr_any && bus.i_lk_req[idx]) begin
        rr_any = 1'b1;
        rr_sel = PW'(idx);
      end
    end
  end

  assign sel_dest   = bus.i_lk_dest[int'(rr_sel)*DW +: DW];
  assign sel_parent = bus.i_lk_parent[int'(rr_sel)*PW +: PW];

  // A pending evaporation blocks both classes; otherwise the fairness toggle
  // breaks the tie only when both classes are waiting.
  assign take_lk  = (state == S_IDLE) && !evap_go && rr_any &&
                    (!bus.i_upd_valid || lk_first);
  assign take_upd = (state == S_IDLE) && !evap_go && bus.i_upd_valid &&
                    (!rr_any || !lk_first);

  always_comb begin
    bus.o_lk_gnt = '0;
    if (take_lk) bus.o_lk_gnt[rr_sel] = 1'b1;
  end

  assign bus.o_upd_ready = take_upd;
  assign bus.o_busy      = (state != S_IDLE);

  // Next hop: strictly-greatest eligible neighbour, lowest index on ties;
  // starting "best" at zero makes an all-zero row fall back to port 0.
  always_comb begin
    logic [PH_WIDTH-1:0] best;
    int                  best_idx;
    best     = '0;
    best_idx = 0;
    for (int n = 1; n < PORTS; n++) begin
      if (n != int'(op_parent) && row_q[n] > best) begin
        best     = row_q[n];
        best_idx = n;
      end
    end
    lk_next           = '0;
    lk_next[best_idx] = 1'b1;
  end

  assign bus.o_rsp_valid = (state == S_LK_RSP);
  assign bus.o_rsp_port  = (state == S_LK_RSP) ? op_port : '0;
  assign bus.o_rsp_next  = (state == S_LK_RSP) ? lk_next : '0;

  // Reinforce the parent (extra bit catches overflow before clamping), decay
  // every other neighbour. An out-of-range parent matches nothing, so all decay.
  always_comb begin
    logic [PH_WIDTH:0] sum;
    sum = '0;
    for (int p = 0; p < PORTS; p++) upd_row[p] = row_q[p];
    for (int p = 1; p < PORTS; p++) begin
      if (p == int'(op_parent)) begin
        sum = {1'b0, row_q[p]} + (PH_WIDTH+1)'(UPD_STEP);
        upd_row[p] = (sum > (PH_WIDTH+1)'(PH_MAX)) ? PH_WIDTH'(PH_MAX) : sum[PH_WIDTH-1:0];
      end else if (row_q[p] > PH_WIDTH'(PH_MIN)) begin
        upd_row[p] = row_q[p] - 1'b1;
      end
    end
  end

`ifdef ANT_EVAPORATION_EN
  localparam int TW = (EVAP_PERIOD > 1) ? $clog2(EVAP_PERIOD) : 1;
  logic [TW-1:0] evap_timer;
  logic          evap_pend;
  logic          evap_wrap;
  logic [DW-1:0] evap_row;
  logic          evap_last;

  assign evap_wrap = (evap_timer == TW'(EVAP_PERIOD - 1));
  assign evap_last = (evap_row == DW'(NODES - 1));
  assign evap_go   = evap_pend;

  // A wrap while already pending is absorbed; a wrap on the final sweep cycle
  // re-arms the flag for the next sweep.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      evap_timer <= '0;
      evap_pend  <= 1'b0;
    end else begin
      evap_timer <= evap_wrap ? '0 : evap_timer + 1'b1;
      if (evap_wrap)
        evap_pend <= 1'b1;
      else if (state == S_EVAP && evap_last)
        evap_pend <= 1'b0;
    end
  end
`else
  assign evap_go = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      op_dest   <= '0;
      op_parent <= '0;
      op_port   <= '0;
      op_is_lk  <= 1'b0;
      op_oor    <= 1'b0;
      lk_first  <= 1'b1;
      rr_ptr    <= '0;
`ifdef ANT_EVAPORATION_EN
      evap_row  <= '0;
`endif
      for (int p = 0; p < PORTS; p++) row_q[p] <= '0;
      for (int r = 0; r < NODES; r++)
        for (int p = 0; p < PORTS; p++)
          tbl[r][p] <= PH_WIDTH'(PH_INIT);
    end else begin
      case (state)
        S_IDLE: begin
`ifdef ANT_EVAPORATION_EN
          if (evap_pend) begin
            state    <= S_EVAP;
            evap_row <= '0;
          end else
`endif
          if (take_lk) begin
            state     <= S_RD;
            op_is_lk  <= 1'b1;
            op_port   <= rr_sel;
            op_dest   <= sel_dest;
            op_parent <= sel_parent;
            op_oor    <= (int'(sel_dest) >= NODES);
            rr_ptr    <= rr_sel;
            lk_first  <= 1'b0;
          end else if (take_upd) begin
            state     <= S_RD;
            op_is_lk  <= 1'b0;
            op_dest   <= bus.i_upd_dest;
            op_parent <= bus.i_upd_parent;
            op_oor    <= (int'(bus.i_upd_dest) >= NODES);
            lk_first  <= 1'b1;
          end
        end
        S_RD: begin
          // An out-of-range row reads as all zeros, so a lookup answers port 0.
          for (int p = 0; p < PORTS; p++)
            row_q[p] <= op_oor ? '0 : tbl[op_dest][p];
          state <= op_is_lk ? S_LK_RSP : S_UPD_WB;
        end
        S_LK_RSP: state <= S_IDLE;
        S_UPD_WB: begin
          if (!op_oor)
            for (int p = 0; p < PORTS; p++) tbl[op_dest][p] <= upd_row[p];
          state <= S_IDLE;
        end
`ifdef ANT_EVAPORATION_EN
        S_EVAP: begin
          for (int p = 0; p < PORTS; p++)
            if (tbl[evap_row][p] > PH_WIDTH'(PH_MIN))
              tbl[evap_row][p] <= tbl[evap_row][p] - 1'b1;
          if (evap_last) state <= S_IDLE;
          else           evap_row <= evap_row + 1'b1;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
